// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences one memory access through IDLE/ACCESS/WAIT/DONE with fixed read latency.
// Optional misaligned-address rejection with err pulse when MISALIGN_CHECK_EN is defined.
module mem_access_ctrl #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        MemReadWrite,
  input  logic        IRWrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        ready,
  output logic [31:0] rdata,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [15:0] imm16,
  output logic        err
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;
  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_rw;
  logic        r_ir;
  logic [31:0] r_rdata;
  logic [5:0]  r_opcode;
  logic [4:0]  r_rs;
  logic [4:0]  r_rt;
  logic [15:0] r_imm16;
  logic        w_accept;
  logic        w_misalign;
  logic        w_start;
  logic        w_last;
  logic [1:0]  w_next;
  assign w_accept = req && (r_state == S_IDLE || r_state == S_DONE);
`ifdef MISALIGN_CHECK_EN
  logic r_err;
  assign w_misalign = addr[1:0] != 2'b00;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_err <= 1'b0;
    else        r_err <= w_accept && w_misalign;
  end
  assign err = r_err;
`else
  assign w_misalign = 1'b0;
  assign err = 1'b0;
`endif
  assign w_start = w_accept && !w_misalign;
  assign w_last  = r_state == S_WAIT && r_cnt == 4'd1;
  always_comb begin
    w_next = (r_state == S_ACCESS) ? S_WAIT :
             (r_state == S_WAIT)   ? (w_last ? S_DONE : S_WAIT) :
             w_start               ? S_ACCESS : S_IDLE;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (r_state == S_ACCESS) ? 4'(WAIT_CYCLES) :
                 (r_state == S_WAIT)   ? r_cnt - 4'd1 : 4'd0;
    end
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_rw    <= 1'b0;
      r_ir    <= 1'b0;
    end else if (w_start) begin
      r_addr  <= addr;
      r_wdata <= wdata;
      r_rw    <= MemReadWrite;
      r_ir    <= IRWrite;
    end
  end
  // Read data is sampled on the edge that closes the last WAIT cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rdata  <= '0;
      r_opcode <= '0;
      r_rs     <= '0;
      r_rt     <= '0;
      r_imm16  <= '0;
    end else if (w_last && !r_rw) begin
      r_rdata <= mem_rdata;
      if (r_ir) begin
        r_opcode <= mem_rdata[31:26];
        r_rs     <= mem_rdata[25:21];
        r_rt     <= mem_rdata[20:16];
        r_imm16  <= mem_rdata[15:0];
      end
    end
  end
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_we    = r_state == S_ACCESS && r_rw;
  assign busy      = r_state == S_ACCESS || r_state == S_WAIT;
  assign ready     = r_state == S_DONE;
  assign rdata     = r_rdata;
  assign opcode    = r_opcode;
  assign rs        = r_rs;
  assign rt        = r_rt;
  assign imm16     = r_imm16;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed checks of mem_access_ctrl with WAIT_CYCLES = 2.
module tb_mem_access_ctrl;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0;
  logic        MemReadWrite = 1'b0;
  logic        IRWrite = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] mem_rdata = 32'hBAD0BAD0;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        busy;
  logic        ready;
  logic [31:0] rdata;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [15:0] imm16;
  logic        err;
  int checks = 0;
  int failures = 0;
  localparam logic [31:0] JUNK = 32'hBAD0BAD0;
  mem_access_ctrl #(.WAIT_CYCLES(2)) dut (
    .clock(clock), .reset(reset), .req(req), .MemReadWrite(MemReadWrite),
    .IRWrite(IRWrite), .addr(addr), .wdata(wdata), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .busy(busy), .ready(ready), .rdata(rdata), .opcode(opcode), .rs(rs),
    .rt(rt), .imm16(imm16), .err(err)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic check_fields(input string tag, input logic [5:0] op, input logic [4:0] s,
                              input logic [4:0] t, input logic [15:0] im);
    check({tag, "_opcode"}, 32'(opcode), 32'(op));
    check({tag, "_rs"}, 32'(rs), 32'(s));
    check({tag, "_rt"}, 32'(rt), 32'(t));
    check({tag, "_imm16"}, 32'(imm16), 32'(im));
  endtask
  // req in cycle 0; memory data presented only in cycle 3 (last WAIT); ends in cycle 4 (DONE).
  task automatic run_access(input string tag, input logic rw, input logic ir,
                            input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd);
    req = 1'b1; MemReadWrite = rw; IRWrite = ir; addr = a; wdata = wd; mem_rdata = JUNK;
    step();
    req = 1'b0;
    check({tag, "_c1_busy"}, 32'(busy), 32'd1);
    check({tag, "_c1_ready"}, 32'(ready), 32'd0);
    check({tag, "_c1_we"}, 32'(mem_we), 32'(rw));
    check({tag, "_c1_addr"}, mem_addr, a);
    check({tag, "_c1_wdata"}, mem_wdata, wd);
    check({tag, "_c1_err"}, 32'(err), 32'd0);
    step();
    check({tag, "_c2_busy"}, 32'(busy), 32'd1);
    check({tag, "_c2_we"}, 32'(mem_we), 32'd0);
    check({tag, "_c2_addr"}, mem_addr, a);
    step();
    mem_rdata = rd;
    check({tag, "_c3_busy"}, 32'(busy), 32'd1);
    check({tag, "_c3_ready"}, 32'(ready), 32'd0);
    check({tag, "_c3_we"}, 32'(mem_we), 32'd0);
    check({tag, "_c3_wdata"}, mem_wdata, wd);
    step();
    mem_rdata = JUNK;
    check({tag, "_c4_ready"}, 32'(ready), 32'd1);
    check({tag, "_c4_busy"}, 32'(busy), 32'd0);
  endtask
  initial begin
    step();
    step();
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check_fields("rst", 6'd0, 5'd0, 5'd0, 16'd0);
    reset = 1'b1;
    // Plain read: rdata updates, fields stay untouched.
    run_access("rd", 1'b0, 1'b0, 32'h10, 32'h0, 32'h8C220004);
    check("rd_rdata", rdata, 32'h8C220004);
    check_fields("rd", 6'd0, 5'd0, 5'd0, 16'd0);
    step();
    check("rd_c5_ready", 32'(ready), 32'd0);
    // Instruction fetch: lw $2, 4($1).
    run_access("if", 1'b0, 1'b1, 32'h10, 32'h0, 32'h8C220004);
    check("if_rdata", rdata, 32'h8C220004);
    check_fields("if", 6'h23, 5'd1, 5'd2, 16'h0004);
    step();
    // Write leaves read result and fields alone.
    run_access("wr", 1'b1, 1'b0, 32'h20, 32'hDEADBEEF, 32'h55555555);
    check("wr_rdata", rdata, 32'h8C220004);
    check_fields("wr", 6'h23, 5'd1, 5'd2, 16'h0004);
    step();
    // Back-to-back: req held high cycles 0..4.
    req = 1'b1; MemReadWrite = 1'b0; IRWrite = 1'b1; addr = 32'h40; mem_rdata = JUNK;
    for (int c = 1; c <= 9; c++) begin
      step();
      if (c == 5) req = 1'b0;
      mem_rdata = (c == 3) ? 32'h11111111 : (c == 7) ? 32'h20430007 : JUNK;
      check($sformatf("b2b_c%0d_ready", c), 32'(ready), 32'((c == 4) || (c == 8)));
      check($sformatf("b2b_c%0d_busy", c), 32'(busy), 32'((c >= 1 && c <= 3) || (c >= 5 && c <= 7)));
      if (c == 4) check("b2b_rdata1", rdata, 32'h11111111);
    end
    check("b2b_rdata2", rdata, 32'h20430007);
    check_fields("b2b", 6'd8, 5'd2, 5'd3, 16'h0007);
    // A req pulse in cycle 2 of a single access must not be queued.
    req = 1'b1; IRWrite = 1'b0; addr = 32'h44;
    for (int c = 1; c <= 8; c++) begin
      step();
      req = (c == 2);
      check($sformatf("ign_c%0d_ready", c), 32'(ready), 32'(c == 4));
      check($sformatf("ign_c%0d_busy", c), 32'(busy), 32'(c >= 1 && c <= 3));
    end
    // Reset in the ACCESS cycle of a write drops outputs without a clock edge.
    req = 1'b1; MemReadWrite = 1'b1; addr = 32'h24; wdata = 32'hCAFEF00D;
    step();
    req = 1'b0;
    check("ab_we_before", 32'(mem_we), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("ab_we", 32'(mem_we), 32'd0);
    check("ab_busy", 32'(busy), 32'd0);
    check("ab_ready", 32'(ready), 32'd0);
    check("ab_addr", mem_addr, 32'd0);
    check("ab_rdata", rdata, 32'd0);
    step();
    reset = 1'b1;
    run_access("ar", 1'b0, 1'b0, 32'h10, 32'h0, 32'h8C220004);
    check("ar_rdata", rdata, 32'h8C220004);
    check_fields("ar", 6'd0, 5'd0, 5'd0, 16'd0);
    step();
`ifdef MISALIGN_CHECK_EN
    req = 1'b1; MemReadWrite = 1'b0; addr = 32'h13;
    step();
    req = 1'b0;
    check("mis_err", 32'(err), 32'd1);
    check("mis_we", 32'(mem_we), 32'd0);
    check("mis_busy", 32'(busy), 32'd0);
    for (int c = 2; c <= 6; c++) begin
      step();
      check($sformatf("mis_c%0d_err", c), 32'(err), 32'd0);
      check($sformatf("mis_c%0d_ready", c), 32'(ready), 32'd0);
      check($sformatf("mis_c%0d_busy", c), 32'(busy), 32'd0);
    end
`else
    run_access("mis", 1'b0, 1'b0, 32'h13, 32'h0, 32'h12345678);
    check("mis_rdata", rdata, 32'h12345678);
    step();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
